// File: rtl/inv_addroundkey_mixcol.sv
// AES-128 inverse round back end: round-key add, then InvMixColumns unless sel=1.
// Define INV_MIX_PARALLEL_EN to mix all four columns in one cycle instead of one per cycle.
module inv_addroundkey_mixcol #(
  parameter bit DONE_STICKY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sel,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MIX  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   st;
  logic [127:0] work;
  logic [127:0] work_mix;
  logic         last_col;
  logic         done_r;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 9, 11, 13, 14 built from x2/x4/x8 xtime chain
  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = c[31-8*i -: 8];
      x2    = xt(a);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef INV_MIX_PARALLEL_EN
  always_comb begin
    work_mix = work;
    for (int c = 0; c < 4; c++) begin
      work_mix[127-32*c -: 32] = imc(work[127-32*c -: 32]);
    end
  end

  assign last_col = 1'b1;
`else
  logic [1:0] col;

  always_comb begin
    work_mix = work;
    work_mix[127-32*col -: 32] = imc(work[127-32*col -: 32]);
  end

  assign last_col = (col == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= 2'd0;
    end else if (st == MIX) begin
      col <= col + 2'd1;
    end else begin
      col <= 2'd0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      work   <= 128'h0;
      done_r <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (en) begin
            work   <= state_in ^ key_in;
            st     <= sel ? DONE : MIX;
            done_r <= sel;
          end
        end
        MIX: begin
          work <= work_mix;
          if (last_col) begin
            st     <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          st     <= IDLE;
          done_r <= DONE_STICKY;
        end
        default: begin
          st     <= IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = work;
  assign busy      = (st != IDLE);
  assign done      = done_r;

endmodule

// File: tb/tb_inv_addroundkey_mixcol.sv
// Self-checking bench for inv_addroundkey_mixcol (default and sticky-done builds).
// Reference model uses a generic GF(2^8) multiply and the InvMixColumns matrix.
module tb_inv_addroundkey_mixcol;

`ifdef INV_MIX_PARALLEL_EN
  localparam int MIX_LAT = 1;
`else
  localparam int MIX_LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sel;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [127:0] state_out;
  logic         busy;
  logic         done;
  logic [127:0] state_out_s;
  logic         busy_s;
  logic         done_s;

  int checks = 0;
  int errors = 0;

  inv_addroundkey_mixcol #(.DONE_STICKY(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .state_in(state_in), .key_in(key_in),
    .state_out(state_out), .busy(busy), .done(done)
  );

  inv_addroundkey_mixcol #(.DONE_STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .state_in(state_in), .key_in(key_in),
    .state_out(state_out_s), .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s,
                                         input logic [127:0] k,
                                         input logic sl);
    logic [7:0]   base [4];
    logic [127:0] x;
    logic [127:0] y;
    logic [7:0]   o;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    x = s ^ k;
    if (sl) return x;
    y = x;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++)
          o ^= gmul(x[127-8*(4*c+j) -: 8], base[(j - r + 4) % 4]);
        y[127-8*(4*c+r) -: 8] = o;
      end
    end
    return y;
  endfunction

  // Drive a request across one accepting edge; inputs are scrambled afterwards.
  task automatic start(input logic [127:0] s, input logic [127:0] k, input logic sl);
    en = 1'b1; sel = sl; state_in = s; key_in = k;
    @(negedge clk);
    en = 1'b0;
    sel = ~sl;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at the negedge just after the accepting edge.
  task automatic finish_op(input string nm, input logic [127:0] exp, input int lat);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== lat || done !== 1'b1) begin
      errors++;
      $display("FAIL %s latency got %0d done=%b want %0d", nm, n, done, lat);
    end
    checks++;
    if (state_out !== exp) begin
      errors++;
      $display("FAIL %s state_out got %h want %h", nm, state_out, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sel = 1'b0; state_in = '0; key_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state_out, busy, done, state_out_s, busy_s, done_s} !== '0) begin
      errors++;
      $display("FAIL reset got %h %b %b want 0 0 0", state_out, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_final_round();
    logic [127:0] s = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
    start(s, k, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_busy got %b want 1", busy);
    end
    finish_op("t1", 128'h00102030405060708090a0b0c0d0e0f0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL t1_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mix();
    start(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0);
    finish_op("t2", 128'hdb135345_f20a225c_01010101_c6c6c6c6, MIX_LAT);
    @(negedge clk);
    start('0, 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101, 1'b0);
    finish_op("t3", 128'hdb135345_d4d4d4d5_2d26314c_01010101, MIX_LAT);
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    start(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0);
    en = 1'b1; sel = 1'b1; state_in = '1; key_in = 128'h5;
    @(negedge clk);
    en = 1'b0;
    finish_op("t4a", 128'hdb135345_f20a225c_01010101_c6c6c6c6, MIX_LAT - 1);
    en = 1'b1; sel = 1'b0; state_in = '0;
    key_in = 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        state_out !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      errors++;
      $display("FAIL t4_en_on_done got busy=%b done=%b out=%h", busy, done, state_out);
    end
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t4_accept busy got %b want 1", busy);
    end
    finish_op("t4b", 128'hdb135345_d4d4d4d5_2d26314c_01010101, MIX_LAT);
    @(negedge clk);
  endtask

  task automatic test_abort();
    start(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (state_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort got %h %b %b want 0 0 0", state_out, busy, done);
    end
    start('0, 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101, 1'b0);
    finish_op("t5", 128'hdb135345_d4d4d4d5_2d26314c_01010101, MIX_LAT);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0] s;
    logic [127:0] k;
    logic         sl;
    for (int i = 0; i < 12; i++) begin
      s  = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      sl = 1'($urandom_range(0, 1));
      start(s, k, sl);
      finish_op("rand", model(s, k, sl), sl ? 0 : MIX_LAT);
      @(negedge clk);
    end
  endtask

  task automatic test_sticky();
    start(128'h00112233445566778899aabbccddeeff,
          128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done_s !== 1'b1 || done !== 1'b0 || busy_s !== 1'b0) begin
        errors++;
        $display("FAIL t6_hold cyc %0d got done_s=%b done=%b want 1 0", i, done_s, done);
      end
    end
    start(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0);
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b1) begin
      errors++;
      $display("FAIL t6_clear got done_s=%b busy_s=%b want 0 1", done_s, busy_s);
    end
    repeat (MIX_LAT) @(negedge clk);
    checks++;
    if (done_s !== 1'b1 || state_out_s !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      errors++;
      $display("FAIL t6_result got done_s=%b out=%h", done_s, state_out_s);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_final_round();
    test_mix();
    test_busy_ignore();
    test_abort();
    test_random();
    test_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
